// File: rtl/fetch_if.sv
// Signal bundle between the IF-stage controller and its environment:
// hazard/branch inputs, the I-cache port and the IF/ID load values.
interface fetch_if;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        ic_hit;
  logic [15:0] ic_instr;
  logic [15:0] ic_addr;
  logic        ic_req;
  logic [15:0] IF_pc;
  logic [15:0] IF_instr;
  logic        if_flush;
  logic        if_stall;
  logic        halted;

  modport master (
    input  stall, br_taken, br_target, ic_hit, ic_instr,
    output ic_addr, ic_req, IF_pc, IF_instr, if_flush, if_stall, halted
  );

  modport slave (
    output stall, br_taken, br_target, ic_hit, ic_instr,
    input  ic_addr, ic_req, IF_pc, IF_instr, if_flush, if_stall, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// IF-stage controller: owns the PC, rides out multi-cycle I-cache misses,
// applies branch redirects and load-use stalls, and parks on HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {RUN, MISS, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        redir_q, redir_d;
  logic [15:0] redir_pc_q, redir_pc_d;

  logic        eff_redir;
  logic        flush;
  logic        hold;

  assign eff_redir = bus.br_taken & ~bus.stall;

  assign bus.ic_addr  = pc_q;
  assign bus.IF_pc    = pc_q + 16'd2;
  assign bus.IF_instr = bus.ic_instr;
  assign bus.halted   = (state_q == HALT);
  assign bus.ic_req   = (state_q != HALT);
  assign bus.if_flush = flush;
  assign bus.if_stall = hold;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    flush      = 1'b0;
    hold       = 1'b0;

    case (state_q)
      HALT: begin
        // Bubbles keep flowing behind the HLT; only a redirect proves it was wrong-path.
        flush = 1'b1;
        hold  = bus.stall;
        if (eff_redir) begin
          pc_d    = bus.br_target;
          state_d = RUN;
        end
      end

      default: begin
        if (!bus.ic_hit) begin
          // The fill cannot be aborted, so pc stays put and redirects are queued.
          if (bus.stall) begin
            hold = 1'b1;
          end else begin
            flush   = 1'b1;
            state_d = MISS;
          end
          if (eff_redir) begin
            redir_d    = 1'b1;
            redir_pc_d = bus.br_target;
          end
        end else if (bus.stall) begin
          hold    = 1'b1;
          state_d = RUN;
        end else if (eff_redir || redir_q) begin
          pc_d    = eff_redir ? bus.br_target : redir_pc_q;
          flush   = 1'b1;
          redir_d = 1'b0;
          state_d = RUN;
        end else if (bus.ic_instr[15:12] == HLT_OPCODE) begin
          state_d = HALT;
        end else begin
          pc_d    = pc_q + 16'd2;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redir_q    <= 1'b0;
      redir_pc_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

endmodule
